bip_control_unit: RTL and testbench
===================================

Name: bip_control_unit

Overview:
Multi-cycle control unit for the 16-bit accumulator processor. It owns the program counter and drives the program memory address. It latches and decodes each instruction word, then emits one cycle of accumulator, ALU and data-memory control strobes per instruction. It stops permanently on HLT. It sits between program memory, data memory and the accumulator/ALU datapath.

Parameters:
addr_bus, 11, width of PC and operand field; program and data memories have 2**addr_bus words
data_size, 16, instruction word width; opcode = Instr[data_size-1 : data_size-5], operand = Instr[addr_bus-1 : 0]

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Run  input  1  start pulse; sampled only in IDLE
Instr  input  data_size  instruction word from program memory (combinational read of Pc)
Pc  output  addr_bus  program counter, drives program memory Addr
Operand  output  addr_bus  operand field of latched instruction (data address or immediate)
Acc_Sel  output  2  accumulator source: 00 data memory, 01 immediate (Operand zero-extended), 10 ALU result
Op_Sel  output  1  ALU operation: 0 add, 1 subtract
Acc_En  output  1  accumulator load enable, one-cycle strobe
Ram_Wr  output  1  data memory write strobe (writes accumulator to Operand)
Ram_Rd  output  1  data memory read enable
Halted  output  1  high once HLT has executed

Behaviour:
- Reset (any state, mid-instruction included): state=IDLE, Pc=0, IR=0, Operand=0, Acc_Sel=00, Op_Sel=0, Acc_En=Ram_Wr=Ram_Rd=0, Halted=0. No strobe is issued in the reset cycle or the cycle after.
- FSM states IDLE, FETCH, EXEC, HALT.
- IDLE: all strobes 0. Run=1 -> FETCH; otherwise stay.
- FETCH: IR <= Instr at the end of the cycle; strobes 0; -> EXEC.
- EXEC: decode IR, drive strobes for exactly this cycle.
  - HLT (00000): no strobes; Pc unchanged; -> HALT.
  - Every other opcode: Pc <= Pc+1, wrapping 2**addr_bus-1 -> 0; -> FETCH.
- Decode table (Acc_Sel/Op_Sel are don't-care when Acc_En=0, but are driven to 00/0):
  - STO (00001): Ram_Wr=1.
  - LD (00010): Ram_Rd=1, Acc_Sel=00, Acc_En=1.
  - LDI (00011): Acc_Sel=01, Acc_En=1.
  - ADD (00100): Ram_Rd=1, Acc_Sel=10, Op_Sel=0, Acc_En=1.
  - ADDI (00101): Acc_Sel=10, Op_Sel=0, Acc_En=1; ALU B operand = Operand.
  - SUB (00110): Ram_Rd=1, Acc_Sel=10, Op_Sel=1, Acc_En=1.
  - SUBI (00111): Acc_Sel=10, Op_Sel=1, Acc_En=1.
  - Opcodes 01000..11111: NOP; no strobes; Pc increments.
- HALT: Halted=1, all strobes 0, Pc frozen at the HLT address. Run is ignored. Only Reset exits.
- Latency: 2 cycles per instruction. The first strobe appears 2 cycles after the Run sample.
- Operand is registered from IR and is stable through EXEC.
- Pc changes only at the end of EXEC, so Instr is stable throughout FETCH.
- At most one of Ram_Wr/Ram_Rd is high in any cycle.
- Run asserted outside IDLE has no effect.

Optional Feature:
INSTR_COUNT_EN
- Defined: adds output Instr_Count [15:0]. It resets to 0 and increments at the end of every EXEC (HLT and NOP included). It saturates at 16'hFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package bip_pkg holds:
  - opcode constants HLT..SUBI (5 bits);
  - FSM state encoding IDLE/FETCH/EXEC/HALT;
  - Acc_Sel encodings ACC_MEM/ACC_IMM/ACC_ALU;
  - OP_ADD/OP_SUB.
- Sub-module bip_pc: the PC register with synchronous reset, increment enable and wrap. The decoder stays inline as a combinational block keyed on IR opcode.

Test Plan:
- Reset then Run: program LDI 16; STO 1; HLT -> EXEC strobes in order:
  - Acc_En, Acc_Sel=01, Operand=16;
  - Ram_Wr, Operand=1;
  - then Halted=1 with Pc=2, held 20 cycles with Run pulsed repeatedly.
- Sequence LD 1; ADDI 255; SUB 2 -> respectively:
  - Ram_Rd=1, Acc_Sel=00;
  - Acc_Sel=10, Op_Sel=0, Operand=255, Ram_Rd=0;
  - Ram_Rd=1, Acc_Sel=10, Op_Sel=1;
  - each strobe exactly 1 cycle, 2 cycles apart.
- Opcode 11111 at address 5 -> no strobes, Pc goes 5->6, execution continues.
- Memory filled with NOP, started at reset -> Pc reaches 2047 then wraps to 0; no Halted.
- Reset asserted during EXEC of an LDI -> no Acc_En that cycle; all outputs at reset values next cycle; Pc=0; state IDLE until Run.
- With INSTR_COUNT_EN, 3 instructions then HLT -> Instr_Count=4 and stays 4 while halted.

Source files
------------

// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, FSM states and datapath select encodings shared by the control unit.
package bip_pkg;
  localparam logic [4:0] HLT  = 5'b00000;
  localparam logic [4:0] STO  = 5'b00001;
  localparam logic [4:0] LD   = 5'b00010;
  localparam logic [4:0] LDI  = 5'b00011;
  localparam logic [4:0] ADD  = 5'b00100;
  localparam logic [4:0] ADDI = 5'b00101;
  localparam logic [4:0] SUB  = 5'b00110;
  localparam logic [4:0] SUBI = 5'b00111;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;
  localparam logic [1:0] ACC_MEM = 2'b00;
  localparam logic [1:0] ACC_IMM = 2'b01;
  localparam logic [1:0] ACC_ALU = 2'b10;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/bip_control_unit_if.sv
// bip_control_unit_if: program-memory, datapath and data-memory control signals.
// Instr_Count exists only when INSTR_COUNT_EN is defined.
interface bip_control_unit_if #(parameter int addr_bus = 11, parameter int data_size = 16);
  logic                 Run;
  logic [data_size-1:0] Instr;
  logic [addr_bus-1:0]  Pc;
  logic [addr_bus-1:0]  Operand;
  logic [1:0]           Acc_Sel;
  logic                 Op_Sel;
  logic                 Acc_En;
  logic                 Ram_Wr;
  logic                 Ram_Rd;
  logic                 Halted;
`ifdef INSTR_COUNT_EN
  logic [15:0]          Instr_Count;
  modport master (input Run, Instr, output Pc, Operand, Acc_Sel, Op_Sel, Acc_En, Ram_Wr, Ram_Rd, Halted, Instr_Count);
  modport slave (output Run, Instr, input Pc, Operand, Acc_Sel, Op_Sel, Acc_En, Ram_Wr, Ram_Rd, Halted, Instr_Count);
`else
  modport master (input Run, Instr, output Pc, Operand, Acc_Sel, Op_Sel, Acc_En, Ram_Wr, Ram_Rd, Halted);
  modport slave (output Run, Instr, input Pc, Operand, Acc_Sel, Op_Sel, Acc_En, Ram_Wr, Ram_Rd, Halted);
`endif
endinterface

// File: rtl/bip_pc.sv
// bip_pc: program counter with synchronous reset and increment enable; wraps naturally at 2**addr_bus.
module bip_pc #(parameter int addr_bus = 11) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                en_i,
  output logic [addr_bus-1:0] pc_o
);
  logic [addr_bus-1:0] pc_q, pc_d;
  always_comb pc_d = en_i ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge Clk) pc_q <= Reset ? '0 : pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit: two-cycle fetch/execute sequencer for the accumulator processor.
// Optional INSTR_COUNT_EN adds a saturating executed-instruction counter.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int addr_bus  = 11,
  parameter int data_size = 16
) (
  input logic Clk,
  input logic Reset,
  bip_control_unit_if.master bus
);
  state_e state_q, state_d;
  logic [data_size-1:0] ir_q, ir_d;
  logic [4:0] opc;
  logic live, pc_en;
  assign opc = ir_q[data_size-1 -: 5];
  // Strobes are masked while Reset is high so a reset landing on EXEC issues nothing.
  assign live  = state_q == EXEC && !Reset;
  assign pc_en = state_q == EXEC && opc != HLT;
  always_comb begin
    ir_d    = state_q == FETCH ? bus.Instr : ir_q;
    state_d = state_q == IDLE  ? (bus.Run ? FETCH : IDLE) :
              state_q == FETCH ? EXEC :
              state_q == EXEC  ? (opc == HLT ? HALT : FETCH) : HALT;
  end
  always_ff @(posedge Clk) begin
    state_q <= Reset ? IDLE : state_d;
    ir_q    <= Reset ? '0 : ir_d;
  end
  bip_pc #(.addr_bus(addr_bus)) u_pc (.Clk(Clk), .Reset(Reset), .en_i(pc_en), .pc_o(bus.Pc));
  always_comb begin
    bus.Ram_Wr  = live && opc == STO;
    bus.Ram_Rd  = live && (opc == LD || opc == ADD || opc == SUB);
    bus.Acc_En  = live && opc >= LD && opc <= SUBI;
    bus.Acc_Sel = !live ? ACC_MEM : opc == LDI ? ACC_IMM : (opc >= ADD && opc <= SUBI) ? ACC_ALU : ACC_MEM;
    bus.Op_Sel  = live && (opc == SUB || opc == SUBI) ? OP_SUB : OP_ADD;
  end
  assign bus.Operand = ir_q[addr_bus-1:0];
  assign bus.Halted  = state_q == HALT;
`ifdef INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == EXEC && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge Clk) cnt_q <= Reset ? '0 : cnt_d;
  assign bus.Instr_Count = cnt_q;
`endif
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: instruction-level interpreter predicts every strobe; a monitor checks them as they appear.
module tb_bip_control_unit;
  import bip_pkg::*;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  typedef struct packed {
    logic [31:0]   t;
    logic [AW-1:0] pc;
    logic [AW-1:0] opnd;
    logic [1:0]    sel;
    logic          ops;
    logic          en;
    logic          wr;
    logic          rd;
  } ev_t;

  logic Clk = 0;
  logic Reset = 1;
  int cyc = 0, n_chk = 0, n_fail = 0, start = 0;
  logic [DW-1:0] mem [N];
  ev_t sb[$], plan[$];
  ev_t act_ev, exp_ev;
  logic [AW-1:0] halt_pc;

  bip_control_unit_if bus ();
  bip_control_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  assign bus.Instr = mem[bus.Pc];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (bus.Acc_En || bus.Ram_Wr || bus.Ram_Rd) begin
      act_ev.t    = cyc;
      act_ev.pc   = bus.Pc;
      act_ev.opnd = bus.Operand;
      act_ev.sel  = bus.Acc_Sel;
      act_ev.ops  = bus.Op_Sel;
      act_ev.en   = bus.Acc_En;
      act_ev.wr   = bus.Ram_Wr;
      act_ev.rd   = bus.Ram_Rd;
      n_chk++;
      if (Reset) begin
        n_fail++;
        $display("FAIL strobe_in_reset: got %h expected none", act_ev);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got %h expected none", act_ev);
      end else begin
        exp_ev = sb.pop_front();
        if (act_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL strobe: got %h expected %h", act_ev, exp_ev);
        end
      end
    end
  end

  // Interprets program memory from address 0; t holds the instruction index until go() converts it to a cycle.
  task automatic model(input int max_i);
    logic [AW-1:0] pc = '0;
    logic [4:0] op;
    ev_t e;
    int i = 0;
    plan.delete();
    while (i < max_i) begin
      op = mem[pc][DW-1 -: 5];
      if (op == HLT) break;
      if (op >= STO && op <= SUBI) begin
        e.t    = i;
        e.pc   = pc;
        e.opnd = mem[pc][AW-1:0];
        e.wr   = op == STO;
        e.rd   = op == LD || op == ADD || op == SUB;
        e.en   = op != STO;
        e.sel  = op == STO ? 2'd0 : op == LD ? 2'd0 : op == LDI ? 2'd1 : 2'd2;
        e.ops  = op == SUB || op == SUBI;
        plan.push_back(e);
      end
      pc++;
      i++;
    end
    halt_pc = pc;
  endtask

  task automatic go();
    @(negedge Clk) bus.Run = 1;
    @(negedge Clk) bus.Run = 0;
    start = cyc;
    foreach (plan[k]) begin
      ev_t e = plan[k];
      e.t = start + 1 + 2 * plan[k].t;
      sb.push_back(e);
    end
  endtask

  task automatic wait_halt(input int budget, input bit noise);
    int n = 0;
    while (!bus.Halted && n < budget) begin
      @(negedge Clk);
      bus.Run = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
    end
    bus.Run = 0;
    chk("halt_reached", bus.Halted, 1);
    chk("halt_pc", bus.Pc, halt_pc);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1;
    repeat (2) @(negedge Clk);
    Reset = 0;
    sb.delete();
  endtask

  task automatic clear_mem();
    foreach (mem[k]) mem[k] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len;
    bus.Run = 0;
    clear_mem();
    do_reset();
    chk("rst_pc", bus.Pc, 0);
    chk("rst_operand", bus.Operand, 0);
    chk("rst_acc_sel", bus.Acc_Sel, 0);
    chk("rst_op_sel", bus.Op_Sel, 0);
    chk("rst_strobes", {bus.Acc_En, bus.Ram_Wr, bus.Ram_Rd}, 0);
    chk("rst_halted", bus.Halted, 0);
    repeat (4) @(negedge Clk);
    chk("idle_pc", bus.Pc, 0);

    mem[0] = {LDI, 11'd16};
    mem[1] = {STO, 11'd1};
    mem[2] = {HLT, 11'd0};
    model(100);
    go();
    wait_halt(50, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk) bus.Run = k[0];
      chk("halt_hold_pc", bus.Pc, 2);
      chk("halt_hold", bus.Halted, 1);
    end
    bus.Run = 0;

    do_reset();
    clear_mem();
    mem[0] = {LD, 11'd1};
    mem[1] = {ADDI, 11'd255};
    mem[2] = {SUB, 11'd2};
    model(100);
    go();
    wait_halt(50, 0);
`ifdef INSTR_COUNT_EN
    chk("instr_count", bus.Instr_Count, 4);
    repeat (10) @(negedge Clk);
    chk("instr_count_hold", bus.Instr_Count, 4);
`endif

    do_reset();
    clear_mem();
    for (int k = 0; k < 5; k++) mem[k] = {LDI, 11'($urandom)};
    mem[5] = {5'b11111, 11'($urandom)};
    mem[6] = {ADD, 11'($urandom)};
    model(100);
    go();
    wait_halt(100, 1);

    repeat (8) begin
      do_reset();
      clear_mem();
      len = $urandom_range(5, 40);
      for (int k = 0; k < len; k++) mem[k] = {5'($urandom_range(1, 31)), 11'($urandom)};
      model(len + 1);
      go();
      wait_halt(2 * len + 20, 1);
    end

    do_reset();
    foreach (mem[k]) mem[k] = {5'($urandom_range(8, 31)), 11'($urandom)};
    plan.delete();
    go();
    for (int k = 0; k < 2 * N + 10 && bus.Pc != AW'(N - 1); k++) @(negedge Clk);
    chk("wrap_reach", bus.Pc, N - 1);
    for (int k = 0; k < 4 && bus.Pc == AW'(N - 1); k++) @(negedge Clk);
    chk("wrap_zero", bus.Pc, 0);
    chk("wrap_not_halted", bus.Halted, 0);

    do_reset();
    clear_mem();
    mem[0] = {LDI, 11'd7};
    plan.delete();
    go();
    @(posedge Clk);
    #1 Reset = 1;
    @(negedge Clk);
    chk("rst_exec_acc_en", bus.Acc_En, 0);
    @(negedge Clk);
    Reset = 0;
    chk("rst_exec_pc", bus.Pc, 0);
    chk("rst_exec_operand", bus.Operand, 0);
    chk("rst_exec_strobes", {bus.Acc_En, bus.Ram_Wr, bus.Ram_Rd}, 0);
    chk("rst_exec_halted", bus.Halted, 0);
    repeat (6) @(negedge Clk);
    chk("rst_exec_idle_pc", bus.Pc, 0);
    model(10);
    go();
    wait_halt(50, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
